// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: hands the fabric clock from the local oscillator to an external PLL clock,
// waiting for the mux switch and PLL lock, with timeouts and a fallback to the local clock.
module clock_switch_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int DONE_TIMEOUT = 1024,
  parameter int GUARD_CYCLES = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_FILTER  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       switch_done,
  input  logic       c_lock,
  output logic       clk_sel,
  output logic       pll_rst,
  output logic       busy,
  output logic       ext_active,
  output logic       fail,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DONE = 3'd1,
    SELECT    = 3'd2,
    PLL_RST   = 3'd3,
    WAIT_LOCK = 3'd4,
    RUN       = 3'd5,
    FALLBACK  = 3'd6,
    ILLEGAL   = 3'd7
  } state_t;
  localparam logic [12:0] DONE_LAST  = 13'(DONE_TIMEOUT - 1);
  localparam logic [12:0] GUARD_LAST = 13'(GUARD_CYCLES - 1);
  localparam logic [12:0] RST_LAST   = 13'(RST_CYCLES - 1);
  localparam logic [12:0] LOCK_LAST  = 13'(LOCK_TIMEOUT - 1);
  localparam logic [12:0] FILT_FULL  = 13'(LOCK_FILTER);
  state_t st, st_n;
  logic [SYNC_STAGES-1:0] done_sync, lock_sync;
  logic [12:0] cnt, filt;
  logic start_q, done_s, lock_s, rise, enter, filt_full;
  assign done_s    = done_sync[SYNC_STAGES-1];
  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign rise      = start & ~start_q;
  assign enter     = st_n != st;
  assign filt_full = filt == FILT_FULL;
  assign state     = st;
  // filt counts lock_s=1 streaks in WAIT_LOCK and lock_s=0 streaks in RUN
  always_comb begin
    st_n = IDLE;
    case (st)
      IDLE:      st_n = rise ? WAIT_DONE : IDLE;
      WAIT_DONE: st_n = !start ? IDLE : done_s ? SELECT : (cnt == DONE_LAST) ? FALLBACK : WAIT_DONE;
      SELECT:    st_n = !start ? IDLE : (cnt == GUARD_LAST) ? PLL_RST : SELECT;
      PLL_RST:   st_n = !start ? IDLE : (cnt == RST_LAST) ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: st_n = !start ? IDLE : filt_full ? RUN : (cnt == LOCK_LAST) ? FALLBACK : WAIT_LOCK;
      RUN:       st_n = filt_full ? FALLBACK : !start ? IDLE : RUN;
      FALLBACK:  st_n = (cnt == RST_LAST) ? IDLE : FALLBACK;
      default:   st_n = IDLE;
    endcase
  end
  // start_q resets high so a start already asserted at reset release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= IDLE;
      done_sync  <= '0;
      lock_sync  <= '0;
      start_q    <= 1'b1;
      cnt        <= '0;
      filt       <= '0;
      clk_sel    <= 1'b0;
      pll_rst    <= 1'b0;
      busy       <= 1'b0;
      ext_active <= 1'b0;
      fail       <= 1'b0;
    end else begin
      st         <= st_n;
      done_sync  <= SYNC_STAGES'({done_sync, switch_done});
      lock_sync  <= SYNC_STAGES'({lock_sync, c_lock});
      start_q    <= start;
      cnt        <= enter ? '0 : cnt + 13'd1;
      filt       <= (enter || !(st inside {WAIT_LOCK, RUN}) || (lock_s ^ (st == WAIT_LOCK))) ? '0 : filt + 13'd1;
      clk_sel    <= st_n inside {SELECT, PLL_RST, WAIT_LOCK, RUN};
      pll_rst    <= st_n inside {PLL_RST, FALLBACK};
      busy       <= !(st_n inside {IDLE, RUN});
      ext_active <= st_n == RUN;
      fail       <= (st_n == FALLBACK) ? 1'b1 : (st == IDLE && rise) ? 1'b0 : fail;
    end
  end
endmodule

// File: doc/clock_switch_ctrl.md
CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth for switch_done and c_lock.
REQ-002 Parameter: DONE_TIMEOUT, 1024, maximum cycles spent in WAIT_DONE.
REQ-003 Parameter: GUARD_CYCLES, 4, cycles clk_sel is held before the PLL reset begins.
REQ-004 Parameter: RST_CYCLES, 16, width of the pll_rst pulse.
REQ-005 Parameter: LOCK_TIMEOUT, 4096, maximum cycles spent in WAIT_LOCK.
REQ-006 Parameter: LOCK_FILTER, 8, consecutive cycles needed to accept lock or lock loss.
REQ-007 Port: clk  input  1  free-running local oscillator clock; the only clock.
REQ-008 Port: reset  input  1  asynchronous, active-low reset.
REQ-009 Port: start  input  1  level request to run on the external clock, synchronous to clk.
REQ-010 Port: switch_done  input  1  asynchronous done flag from the clock-switch stage.
REQ-011 Port: c_lock  input  1  asynchronous PLL lock indicator.
REQ-012 Port: clk_sel  output  1  BUFGMUX select: 0 = local, 1 = external.
REQ-013 Port: pll_rst  output  1  active-high PLL reset.
REQ-014 Port: busy  output  1  high in any state other than IDLE and RUN.
REQ-015 Port: ext_active  output  1  high only in RUN.
REQ-016 Port: fail  output  1  sticky timeout or lock-loss flag.
REQ-017 Port: state  output  3  current FSM state encoding.

Function
REQ-018 switch_done and c_lock SHALL each pass through a SYNC_STAGES flop synchronizer before any use; the sync outputs are called done_s and lock_s.
REQ-019 The FSM SHALL use these encodings: IDLE=0, WAIT_DONE=1, SELECT=2, PLL_RST=3, WAIT_LOCK=4, RUN=5, FALLBACK=6; code 7 SHALL return to IDLE on the next cycle.
REQ-020 A single 13-bit cycle counter SHALL clear on every state entry and increment once per cycle while in a state.
REQ-021 IDLE: on a start 0->1 edge (registered), fail SHALL clear and the FSM SHALL go to WAIT_DONE.
REQ-022 WAIT_DONE: done_s=1 SHALL go to SELECT; otherwise, counter=DONE_TIMEOUT-1 SHALL go to FALLBACK; done_s SHALL win when both occur in the same cycle.
REQ-023 SELECT: clk_sel SHALL be 1 from entry; after GUARD_CYCLES cycles the FSM SHALL go to PLL_RST.
REQ-024 PLL_RST: pll_rst SHALL be 1 for exactly RST_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK.
REQ-025 WAIT_LOCK: a filter counter SHALL count consecutive lock_s=1 cycles and reset to 0 on lock_s=0.
REQ-026 WAIT_LOCK: filter=LOCK_FILTER SHALL go to RUN; otherwise, counter=LOCK_TIMEOUT-1 SHALL go to FALLBACK; lock wins when both occur in the same cycle.
REQ-027 RUN: ext_active SHALL be 1 and clk_sel SHALL be 1.
REQ-028 RUN: LOCK_FILTER consecutive lock_s=0 cycles SHALL go to FALLBACK.
REQ-029 RUN: start=0 SHALL go to IDLE with clk_sel=0 and fail unchanged.
REQ-030 RUN: when lock loss and start=0 occur in the same cycle, FALLBACK SHALL win.
REQ-031 start=0 in WAIT_DONE, SELECT, PLL_RST or WAIT_LOCK SHALL abort to IDLE with clk_sel=0 and pll_rst=0 on the next cycle, with no fail.
REQ-032 FALLBACK: clk_sel SHALL be 0 and fail SHALL set on entry; pll_rst SHALL be 1 for RST_CYCLES cycles; the FSM SHALL then go to IDLE.
REQ-033 After FALLBACK, a new start rising edge SHALL be required to retry.
REQ-034 clk_sel SHALL be 0 in IDLE, WAIT_DONE and FALLBACK, and 1 in SELECT, PLL_RST, WAIT_LOCK and RUN.
REQ-035 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-036 reset=0 SHALL asynchronously force: state=IDLE, clk_sel=0, pll_rst=0, busy=0, ext_active=0, fail=0, counters=0, synchronizers=0.
REQ-037 Reset deassertion mid-operation SHALL restart from IDLE; a start already high at deassertion SHALL NOT count as an edge.

Verification
REQ-038 Nominal: start 0->1, switch_done high at cycle 20, c_lock high 30 cycles after pll_rst falls -> SELECT, pll_rst high for 16 cycles, RUN; ext_active=1, fail=0.
REQ-039 Done timeout: start 0->1, switch_done held 0 -> FALLBACK after 1024 cycles in WAIT_DONE, fail=1, clk_sel=0, 16-cycle pll_rst, then IDLE.
REQ-040 Lock glitch filter: c_lock high for 5 cycles, low for 1, then high for 8 in WAIT_LOCK -> RUN entered only after the 8-cycle run; a 7-cycle drop in RUN is ignored; an 8-cycle drop -> FALLBACK, fail=1.
REQ-041 Abort: start drops in PLL_RST at cycle 5 -> IDLE next cycle, pll_rst=0, clk_sel=0, fail=0.
REQ-042 Simultaneous events: done_s rises on the timeout cycle -> SELECT, not FALLBACK; lock loss and start=0 on the same cycle in RUN -> FALLBACK.
REQ-043 Async reset asserted in WAIT_LOCK between clock edges -> all outputs 0 immediately; start held high through reset release -> FSM stays in IDLE.
